wb_unit: RTL

Parametrised write-back stage for the pipelined processor; successor to the purely combinational write-back mux. Selects ALU result or load data and drives the register-file write port (ResultW_o / WriteRegW_o / RegWriteW_o) to ID through a registered output. It also supports variable-latency data memory via a valid handshake with upstream stall, sub-word (half-width) loads with sign/zero extension, and a load timeout with a sticky error flag.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_load_align.sv | 25 ++
 rtl/wb_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types for the write-back stage
package wb_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

  // Sub-word load controls captured while a load waits for memory
  typedef struct packed {
    logic half;
    logic half_sel;
    logic sign_ext;
  } load_mode_t;

  localparam logic HALF_LOW  = 1'b0;
  localparam logic HALF_HIGH = 1'b1;
  localparam logic EXT_ZERO  = 1'b0;
  localparam logic EXT_SIGN  = 1'b1;

endpackage

// File: rtl/wb_load_align.sv
// rtl/wb_load_align.sv - full-word or half-word select with zero/sign extension
module wb_load_align
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  load_mode_t            mode,
  output logic [DATA_WIDTH-1:0] aligned
);

  localparam int H = DATA_WIDTH / 2;

  logic [H-1:0] part;

  always_comb begin
    part    = (mode.half_sel == HALF_HIGH) ? data[DATA_WIDTH-1:H] : data[H-1:0];
    aligned = data;
    if (mode.half) begin
      if (mode.sign_ext == EXT_SIGN) aligned = {{H{part[H-1]}}, part};
      else                           aligned = {{H{1'b0}}, part};
    end
  end

endmodule

// File: rtl/wb_unit.sv
// rtl/wb_unit.sv - registered write-back stage with load wait/timeout; optional WB_RETIRE_CNT_EN retire counter
module wb_unit
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int REG_WIDTH    = 4,
  parameter int MEM_TIMEOUT  = 15,
  parameter int TO_CNT_WIDTH = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] WBResultW_i,
  input  logic [REG_WIDTH-1:0]  WriteRegW_i,
  input  logic                  RegWriteW_i,
  input  logic                  MemToRegW_i,
  input  logic                  LoadHalfW_i,
  input  logic                  HalfSelW_i,
  input  logic                  LoadSignedW_i,
  input  logic                  memData_valid_i,
  input  logic [DATA_WIDTH-1:0] memData_r_i,
  output logic                  stallW_o,
  output logic                  RegWriteW_o,
  output logic [REG_WIDTH-1:0]  WriteRegW_o,
  output logic [DATA_WIDTH-1:0] ResultW_o,
`ifdef WB_RETIRE_CNT_EN
  output logic [CNT_WIDTH-1:0]  retire_cnt_o,
`endif
  output logic                  timeout_err_o
);

  wb_state_t             state, state_n;
  logic [TO_CNT_WIDTH-1:0] to_cnt, to_cnt_n;
  logic [REG_WIDTH-1:0]  lat_reg;
  logic                  lat_we;
  load_mode_t            lat_mode;

  load_mode_t            up_mode, sel_mode;
  logic [DATA_WIDTH-1:0] aligned;
  logic                  commit, drop, latch;
  logic                  sel_we;
  logic [REG_WIDTH-1:0]  sel_reg;
  logic [DATA_WIDTH-1:0] sel_result;

  assign up_mode  = '{half: LoadHalfW_i, half_sel: HalfSelW_i, sign_ext: LoadSignedW_i};
  assign sel_mode = (state == WAIT_MEM) ? lat_mode : up_mode;

  wb_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .data    (memData_r_i),
    .mode    (sel_mode),
    .aligned (aligned)
  );

  always_comb begin
    state_n    = state;
    to_cnt_n   = to_cnt;
    commit     = 1'b0;
    drop       = 1'b0;
    latch      = 1'b0;
    stallW_o   = 1'b0;
    sel_we     = RegWriteW_i;
    sel_reg    = WriteRegW_i;
    sel_result = MemToRegW_i ? aligned : WBResultW_i;
    case (state)
      IDLE: begin
        if (valid_i) begin
          if (!MemToRegW_i || memData_valid_i) begin
            commit = 1'b1;
          end else begin
            latch    = 1'b1;
            stallW_o = 1'b1;
            state_n  = WAIT_MEM;
            to_cnt_n = TO_CNT_WIDTH'(1);
          end
        end
      end
      WAIT_MEM: begin
        // Upstream is frozen here, so only the latched controls matter
        stallW_o   = 1'b1;
        sel_we     = lat_we;
        sel_reg    = lat_reg;
        sel_result = aligned;
        if (memData_valid_i) begin
          commit  = 1'b1;
          state_n = IDLE;
        end else if (to_cnt == TO_CNT_WIDTH'(MEM_TIMEOUT)) begin
          drop    = 1'b1;
          state_n = IDLE;
        end else begin
          to_cnt_n = to_cnt + TO_CNT_WIDTH'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      to_cnt        <= '0;
      lat_reg       <= '0;
      lat_we        <= 1'b0;
      lat_mode      <= '0;
      RegWriteW_o   <= 1'b0;
      WriteRegW_o   <= '0;
      ResultW_o     <= '0;
      timeout_err_o <= 1'b0;
    end else begin
      state       <= state_n;
      to_cnt      <= to_cnt_n;
      RegWriteW_o <= commit & sel_we;
      if (latch) begin
        lat_reg  <= WriteRegW_i;
        lat_we   <= RegWriteW_i;
        lat_mode <= up_mode;
      end
      if (commit) begin
        WriteRegW_o <= sel_reg;
        ResultW_o   <= sel_result;
      end
      if (drop) timeout_err_o <= 1'b1;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  retire_cnt_o <= '0;
    else if (commit & sel_we) retire_cnt_o <= retire_cnt_o + CNT_WIDTH'(1);
  end
`endif

endmodule
